// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the SRAM memory-stage controller.
// Contents: FSM state enum, default base address / wait cycles / SRAM address
// width, and the half-select bit appended to a word index to form a half-word
// address.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_t;

  localparam int unsigned MEM_BASE_ADDR   = 1024;
  localparam int unsigned MEM_WAIT_CYCLES = 5;
  localparam int unsigned MEM_SRAM_AW     = 18;

  // Half-word address LSB: selects data[15:0] or data[31:16] (little-endian).
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter shared by the LOW and HIGH half-word phases.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force count to 0 (has priority over en)
//   en        - increment count
//   last      - count == WAIT_CYCLES-1, i.e. final cycle of a phase
module mem_wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (clr) begin
      cnt_q <= 4'd0;
    end else if (en) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign last = (cnt_q == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two half-word
// accesses on a 16-bit asynchronous SRAM, each held WAIT_CYCLES cycles, and
// holds ready low to freeze the pipeline until the word completes.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   rd_en, wr_en           - load / store request (both set => store)
//   address, write_data    - byte address (word aligned) and store data
//   read_data              - last completed load result
//   ready                  - 0 stalls the pipeline
//   sram_addr, sram_wdata  - registered SRAM half-word address / write data
//   sram_rdata             - SRAM read data
//   sram_we_n              - active-low SRAM write enable
// Optional feature: define SRAM_MEM_CTRL_RDBUF_EN to add a one-entry read buffer
// that answers a repeated load of the same word in zero stall cycles.
module sram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = MEM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = MEM_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = MEM_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n
);

  mem_state_t state_q, state_d;

  logic               req, hit, start, last;
  logic               cnt_clr, cnt_en;
  logic [31:0]        addr_off;
  logic [SRAM_AW-2:0] cur_word;
  logic               unused_addr_bits;

  logic               is_wr_q;
  logic [15:0]        wdata_hi_q;
  logic [31:0]        rdata_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [15:0]        sram_wdata_q;

  assign req      = rd_en | wr_en;
  assign addr_off = address - 32'(BASE_ADDR);
  // Word index truncated to the SRAM; negative offsets wrap silently.
  assign cur_word = addr_off[SRAM_AW:2];
  assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};
  assign start    = (state_q == IDLE) & req & ~hit;

  mem_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .last(last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOW;
      LOW:     if (last)  state_d = HIGH;
      HIGH:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and counter control
  always_comb begin
    ready     = ((state_q == IDLE) & ~req) | (state_q == DONE) | hit;
    sram_we_n = ~(is_wr_q & ((state_q == LOW) | (state_q == HIGH)));
    cnt_en    = (state_q == LOW) | (state_q == HIGH);
    // Counter restarts at the start of each phase.
    cnt_clr   = (state_q == IDLE) | (state_q == DONE) | ((state_q == LOW) & last);
  end

  // Request capture and half-word sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q      <= 1'b0;
      wdata_hi_q   <= 16'd0;
      rdata_q      <= 32'd0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 16'd0;
    end else if (start) begin
      is_wr_q      <= wr_en;
      wdata_hi_q   <= write_data[31:16];
      sram_addr_q  <= {cur_word, HALF_LO};
      sram_wdata_q <= write_data[15:0];
    end else if ((state_q == LOW) && last) begin
      sram_addr_q  <= {sram_addr_q[SRAM_AW-1:1], HALF_HI};
      sram_wdata_q <= wdata_hi_q;
      if (!is_wr_q) rdata_q[15:0] <= sram_rdata;
    end else if ((state_q == HIGH) && last) begin
      if (!is_wr_q) rdata_q[31:16] <= sram_rdata;
    end
  end

  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

`ifdef SRAM_MEM_CTRL_RDBUF_EN
  logic               buf_valid_q;
  logic [SRAM_AW-2:0] buf_tag_q;
  logic [31:0]        buf_data_q;

  // Tag is the SRAM word index, so aliased addresses share an entry like the SRAM.
  assign hit = (state_q == IDLE) & rd_en & ~wr_en & buf_valid_q & (buf_tag_q == cur_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= 32'd0;
    end else if ((state_q == DONE) && !is_wr_q) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= sram_addr_q[SRAM_AW-1:1];
      buf_data_q  <= rdata_q;
    end else if (start && wr_en && (buf_tag_q == cur_word)) begin
      buf_valid_q <= 1'b0;
    end
  end

  assign read_data = hit ? buf_data_q : rdata_q;
`else
  assign hit       = 1'b0;
  assign read_data = rdata_q;
`endif

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-stage controller that sequences the pipeline's 32-bit loads and stores onto an external 16-bit asynchronous SRAM. Each word is transferred as two half-word accesses, each held for a fixed number of wait cycles. The controller drives `ready` low to freeze the pipeline until the access completes. It sits between the EXE/MEM pipeline register and the SRAM pins, and is driven by the EXE stage's `mem_r_en`, `mem_w_en`, ALU result (address) and Rm value (store data).

## Interface
- `BASE_ADDR`, default 1024: byte address of data word 0; subtracted before SRAM address mapping.
- `WAIT_CYCLES`, default 5: cycles each half-word access is held; legal range 1–15.
- `SRAM_AW`, default 18: SRAM half-word address width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in 1: load request.
- `wr_en` in 1: store request.
- `address` in 32: byte address, word-aligned; bits [1:0] ignored.
- `write_data` in 32: store data.
- `read_data` out 32: load result; valid while `ready`=1 in DONE, and held until the next load completes.
- `ready` out 1: 0 freezes the pipeline.
- `sram_addr` out SRAM_AW: half-word address.
- `sram_wdata` out 16: write half.
- `sram_rdata` in 16: read half.
- `sram_we_n` out 1: active-low write enable.

## Operation
- Request: `req = rd_en | wr_en`. If both are asserted, the access is a store.
- Word index: `w = (address - BASE_ADDR) >> 2`, 32-bit subtraction.
- Half addresses: low half at `{w,1'b0}`, high half at `{w,1'b1}`, truncated to SRAM_AW bits. Addresses below BASE_ADDR wrap modulo 2^SRAM_AW; no fault is raised.
- Byte order is little-endian: the low half carries data[15:0].
- States: IDLE, LOW, HIGH, DONE.
  - IDLE: on `req`, go to LOW and clear the counter.
  - LOW: hold for WAIT_CYCLES cycles, then go to HIGH and clear the counter.
  - HIGH: hold for WAIT_CYCLES cycles, then go to DONE.
  - DONE: go to IDLE unconditionally.
- `ready = (IDLE & ~req) | DONE`, combinational.
- Loads: `sram_rdata` is captured into `read_data[15:0]` on the last LOW cycle and into `read_data[31:16]` on the last HIGH cycle.
- Stores: `sram_we_n` = 0 throughout LOW and HIGH, 1 otherwise. `sram_wdata` = write_data[15:0] in LOW and write_data[31:16] in HIGH.
- `sram_addr` is registered: it is loaded with the low-half address on the IDLE→LOW edge and with the high-half address on the LOW→HIGH edge.
- The requester holds `address`, `write_data`, `rd_en` and `wr_en` stable while `ready`=0. Changes while `ready`=0 are undefined; the controller uses the values captured on entry to LOW.
- A request present in DONE is ignored. It is accepted on the following IDLE cycle (the pipeline advances on DONE, so the next instruction's request arrives in IDLE).

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_wdata` 0, `sram_we_n` 1, `ready` = ~req.
- Request first seen at cycle 0 in IDLE:
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE is cycle 2W+1.
- `ready` is 0 for cycles 0..2W, i.e. 2W+1 stall cycles; it is 1 at cycle 2W+1.
- Back-to-back requests: the second request's cycle 0 is at 2W+2.
- `rst` asserted mid-access: next cycle is IDLE with `sram_we_n`=1. A partial SRAM write may persist; no retry is attempted.

## Configuration
- `SRAM_MEM_CTRL_RDBUF_EN` defined: adds a one-entry read buffer (valid bit, word tag, 32-bit data), filled on every load completion.
  - A load in IDLE whose word matches a valid tag is a hit: `ready`=1 in the same cycle, `read_data` is driven from the buffer, and no SRAM cycle or state change occurs.
  - A store to the tagged word invalidates the buffer on entry to LOW.
  - Reset clears the valid bit.
- Not defined: every load takes the full 2W+1-cycle sequence; no buffer flops exist.

## Structure
- Package `mem_ctrl_pkg`:
  - State enum `mem_state_t` {IDLE, LOW, HIGH, DONE}.
  - Defaults `MEM_BASE_ADDR` = 1024 and `MEM_WAIT_CYCLES` = 5.
  - Half-select constants.
- Sub-module `mem_wait_counter`: 4-bit counter with `clr` and `en` inputs and a `last` output (asserted when count == WAIT_CYCLES-1). Instantiated once and shared by LOW and HIGH.

## Test plan
All scenarios use W=5, BASE=1024.
- Reset: `rst`=1 for 2 cycles with `rd_en`=0 → `ready`=1, `sram_we_n`=1, `read_data`=0, state IDLE.
- Store: `wr_en`, address 1028, data 0xDEADBEEF →
  - `sram_addr`=2 with wdata 0xBEEF for 5 cycles, then `sram_addr`=3 with 0xDEAD for 5 cycles;
  - `sram_we_n` low for exactly 10 cycles;
  - `ready`=0 for 11 cycles.
- Load: SRAM model holds 2→0xBEEF, 3→0xDEAD; `rd_en`, address 1028 → `read_data`=0xDEADBEEF at cycle 11 with `ready`=1.
- Simultaneous: `rd_en`=`wr_en`=1, address 1032, data 0x12345678 → store to half addresses 4 and 5; `read_data` unchanged.
- Reset mid-access: `rst` at cycle 7 of a store → IDLE next cycle, `sram_we_n`=1, `ready`=1.
- `SRAM_MEM_CTRL_RDBUF_EN` defined:
  - repeated load of 1028 → second load `ready`=1 in cycle 0 with 0xDEADBEEF;
  - store to 1028, then load 1028 → full 11-cycle stall.
